// File: rtl/order_tx_if.sv
// Order frame byte stream: order_tx drives data/valid/last, the consumer drives ready.
interface order_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/order_tx.sv
// Order transmitter: turns buy/sell requests into A5-framed order bytes, tracks the
// net position against MAX_POS and counts dropped requests (saturating).
// Optional feature macro ORDER_TX_CHECKSUM_EN: appends an XOR checksum byte (4-byte frames);
// undefined gives 3-byte frames with no checksum logic.
module order_tx #(
    parameter int unsigned MAX_POS  = 8,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buy_signal,
    input  logic              sell_signal,
    input  logic [7:0]        price,
    order_tx_if.master        tx,
    output logic [7:0]        position,
    output logic [7:0]        drop_count,
    output logic              busy
);

`ifdef ORDER_TX_CHECKSUM_EN
    localparam logic [1:0] LastIdx = 2'd3;
`else
    localparam logic [1:0] LastIdx = 2'd2;
`endif

    localparam logic [7:0]        SyncByte = 8'hA5;
    localparam logic signed [7:0] PosMax   = 8'(MAX_POS);
    localparam logic signed [7:0] PosMin   = -PosMax;
    localparam logic [7:0]        CoolLoad = 8'(COOLDOWN);

    typedef enum logic [1:0] {StIdle, StSend, StCool} state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              side_q, side_d;
    logic [7:0]        price_q, price_d;
    logic [3:0]        seq_q, seq_d;
    logic signed [7:0] pos_q, pos_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        cool_q, cool_d;
    logic              drop_evt;
    logic [7:0]        hdr_byte;

    assign hdr_byte = {side_q, 3'b000, seq_q};

    // Next-state: request arbitration in IDLE, byte handshake in SEND, countdown in COOL.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        side_d   = side_q;
        price_d  = price_q;
        seq_d    = seq_q;
        pos_d    = pos_q;
        cool_d   = cool_q;
        drop_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (buy_signal && sell_signal) begin
                    drop_evt = 1'b1;
                end else if (buy_signal) begin
                    if (pos_q < PosMax) begin
                        side_d  = 1'b1;
                        price_d = price;
                        pos_d   = pos_q + 8'sd1;
                        idx_d   = 2'd0;
                        state_d = StSend;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end else if (sell_signal) begin
                    if (pos_q > PosMin) begin
                        side_d  = 1'b0;
                        price_d = price;
                        pos_d   = pos_q - 8'sd1;
                        idx_d   = 2'd0;
                        state_d = StSend;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            StSend: begin
                drop_evt = buy_signal | sell_signal;
                if (tx.tx_ready) begin
                    if (idx_q == LastIdx) begin
                        seq_d  = seq_q + 4'd1;
                        cool_d = CoolLoad;
                        // A zero cooldown skips COOL entirely.
                        state_d = (CoolLoad == 8'd0) ? StIdle : StCool;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StCool: begin
                drop_evt = buy_signal | sell_signal;
                cool_d   = cool_q - 8'd1;
                if (cool_q <= 8'd1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        drop_d = (drop_evt && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // State registers with synchronous reset; reset also discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            side_q  <= 1'b0;
            price_q <= 8'd0;
            seq_q   <= 4'd0;
            pos_q   <= 8'sd0;
            drop_q  <= 8'd0;
            cool_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            side_q  <= side_d;
            price_q <= price_d;
            seq_q   <= seq_d;
            pos_q   <= pos_d;
            drop_q  <= drop_d;
            cool_q  <= cool_d;
        end
    end

    // Output byte mux; data is forced to zero outside SEND.
    always_comb begin
        tx.tx_data  = 8'd0;
        tx.tx_valid = (state_q == StSend);
        tx.tx_last  = (state_q == StSend) && (idx_q == LastIdx);
        if (state_q == StSend) begin
            case (idx_q)
                2'd0:    tx.tx_data = SyncByte;
                2'd1:    tx.tx_data = hdr_byte;
                2'd2:    tx.tx_data = price_q;
`ifdef ORDER_TX_CHECKSUM_EN
                2'd3:    tx.tx_data = SyncByte ^ hdr_byte ^ price_q;
`endif
                default: tx.tx_data = 8'd0;
            endcase
        end
    end

    assign position   = pos_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_order_tx.sv
// Scoreboard bench for order_tx: stimulus drives a rule-level model that queues expected
// frame bytes; an independent monitor pops and compares on each accepted byte.
module tb_order_tx;
    localparam int MaxPos   = 8;
    localparam int Cooldown = 4;
`ifdef ORDER_TX_CHECKSUM_EN
    localparam int FrameLen = 4;
`else
    localparam int FrameLen = 3;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       buy;
    logic       sell;
    logic [7:0] price;
    logic [7:0] position;
    logic [7:0] drop_count;
    logic       busy;

    order_tx_if tx ();

    order_tx #(
        .MAX_POS (MaxPos),
        .COOLDOWN(Cooldown)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buy_signal (buy),
        .sell_signal(sell),
        .price      (price),
        .tx         (tx),
        .position   (position),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: net position, drop count, seq, bytes still owed, cooldown cycles still owed.
    int m_pos, m_drop, m_seq, m_left, m_cool;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_pos  = 0;
        m_drop = 0;
        m_seq  = 0;
        m_left = 0;
        m_cool = 0;
        exp_q.delete();
    endtask

    task automatic push_frame(input logic side, input logic [7:0] pr);
        logic [7:0] b [4];
        exp_t e;
        logic [3:0] s;
        s    = 4'(m_seq);
        b[0] = 8'hA5;
        b[1] = {side, 3'b000, s};
        b[2] = pr;
        b[3] = b[0] ^ b[1] ^ b[2];
        for (int i = 0; i < FrameLen; i++) begin
            e.data = b[i];
            e.last = (i == FrameLen - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic add_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Effect of one clock edge given this cycle's inputs.
    task automatic model_step(input logic b, input logic s, input logic [7:0] pr,
                              input logic rdy);
        if (m_left == 0 && m_cool == 0) begin
            if (b && s) add_drop();
            else if (b) begin
                if (m_pos < MaxPos) begin
                    m_pos++;
                    push_frame(1'b1, pr);
                    m_left = FrameLen;
                end else add_drop();
            end else if (s) begin
                if (m_pos > -MaxPos) begin
                    m_pos--;
                    push_frame(1'b0, pr);
                    m_left = FrameLen;
                end else add_drop();
            end
        end else if (m_left > 0) begin
            if (b || s) add_drop();
            if (rdy) begin
                m_left--;
                if (m_left == 0) begin
                    m_seq  = (m_seq + 1) % 16;
                    m_cool = Cooldown;
                end
            end
        end else begin
            if (b || s) add_drop();
            m_cool--;
        end
    endtask

    task automatic step(input logic b, input logic s, input logic [7:0] pr, input logic rdy);
        buy         = b;
        sell        = s;
        price       = pr;
        tx.tx_ready = rdy;
        model_step(b, s, pr, rdy);
        @(posedge clk);
        #1;
        check("position", $signed(position), m_pos);
        check("drop_count", drop_count, m_drop);
        check("busy", busy, (m_left > 0 || m_cool > 0) ? 1 : 0);
        check("tx_valid", tx.tx_valid, (m_left > 0) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        buy         = 1'b0;
        sell        = 1'b0;
        price       = 8'h00;
        tx.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", tx.tx_valid, 0);
        check("rst_tx_last", tx.tx_last, 0);
        check("rst_tx_data", tx.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_position", position, 0);
        check("rst_drop_count", drop_count, 0);
        model_clear();
        rst = 1'b0;
    endtask

    // Monitor: byte compare on each handshake, plus hold-stable checks across stalls.
    initial begin
        logic       stalled;
        logic [7:0] held_data;
        logic       held_last;
        exp_t       e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", tx.tx_valid, 1);
                    check("stall_data", tx.tx_data, held_data);
                    check("stall_last", tx.tx_last, held_last);
                end
                stalled   = tx.tx_valid && !tx.tx_ready;
                held_data = tx.tx_data;
                held_last = tx.tx_last;
                if (tx.tx_valid && tx.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %02h expected none at %0t",
                                 tx.tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx.tx_data, e.data);
                        check("tx_last", tx.tx_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        model_clear();
        do_reset();

        // Buy at 0x3C, ready high; a second buy afterwards carries seq 1.
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        idle(12);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        idle(12);
        check("two_buys_pos", $signed(position), 2);

        // Sell at 0x10 with ready low for 3 cycles on byte1.
        do_reset();
        step(1'b0, 1'b1, 8'h10, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("stall_byte1", tx.tx_data, 8'h00);
        idle(12);
        check("sell_pos", $signed(position), -1);

        // Conflict in IDLE.
        do_reset();
        step(1'b1, 1'b1, 8'h20, 1'b1);
        idle(2);
        check("conflict_drop", drop_count, 1);
        check("conflict_pos", position, 0);

        // Nine spaced buys against the limit of 8.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1);
            idle(9);
        end
        check("limit_pos", $signed(position), 8);
        check("limit_drop", drop_count, 1);

        // Held buy for 20 cycles: frames back to back, held cycles counted as drops.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
        idle(12);

        // Reset during byte1: frame aborts, position and seq cleared.
        do_reset();
        step(1'b1, 1'b0, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        rst         = 1'b1;
        tx.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid", tx.tx_valid, 0);
        check("abort_pos", position, 0);
        model_clear();
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h66, 1'b1);
        idle(12);

        // Randomised traffic with random backpressure.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end

        // Conflicts held long enough to saturate the drop counter.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'h00, 1'b1);
        check("drop_saturated", drop_count, 255);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) idle(1);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
